servo_pwm_driver: RTL

SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

---
 rtl/servo_pwm_driver_if.sv | 19 +
 rtl/servo_pwm_driver.sv | 94 +++++++++
 2 files changed

// File: rtl/servo_pwm_driver_if.sv
// rtl/servo_pwm_driver_if.sv - angle command and PWM status bundle for the servo driver
interface servo_pwm_driver_if;
  logic [11:0] angle;
  logic        valid;
  logic        pwm;
  logic [11:0] current_angle;
  logic [20:0] pulse_width;
  logic        frame_start;

  modport master (
    output angle, valid,
    input  pwm, current_angle, pulse_width, frame_start
  );

  modport slave (
    input  angle, valid,
    output pwm, current_angle, pulse_width, frame_start
  );
endinterface

// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - slew-limited servo PWM generator with shift-add width computation
module servo_pwm_driver #(
  parameter int PERIOD_CYCLES = 2000000,
  parameter int MIN_PULSE     = 100000,
  parameter int MAX_PULSE     = 200000,
  parameter int SLEW_STEP     = 16
) (
  input  logic                clock,
  input  logic                reset,
  servo_pwm_driver_if.slave   bus
);

  localparam logic [20:0] LAST_CNT  = 21'(PERIOD_CYCLES - 1);
  localparam logic [29:0] RANGE     = 30'(MAX_PULSE - MIN_PULSE);
  localparam logic [20:0] MIN_W     = 21'(MIN_PULSE);
  // 2048/4096 of the range is exactly half of it, floored
  localparam logic [20:0] MID_W     = 21'(MIN_PULSE + (MAX_PULSE - MIN_PULSE) / 2);
  localparam logic signed [12:0] STEP = 13'(SLEW_STEP);
  localparam logic [11:0] STEP12    = 12'(SLEW_STEP);
  localparam logic [11:0] LEVEL     = 12'd2048;

  typedef enum logic [1:0] {IDLE, SLEW, MULT, DONE} state_t;

  state_t      state_q, state_d;
  logic [20:0] cnt;
  logic [11:0] target;
  logic [11:0] cur_angle;
  logic [29:0] product;
  logic [3:0]  bit_idx;
  logic [20:0] next_width;
  logic [20:0] pulse_width;
  logic        pwm_q;
  logic signed [12:0] diff;

  assign diff = $signed({1'b0, target}) - $signed({1'b0, cur_angle});

  assign bus.pwm           = pwm_q;
  assign bus.current_angle = cur_angle;
  assign bus.pulse_width   = pulse_width;
  assign bus.frame_start   = (cnt == 21'd0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt == 21'd0) state_d = SLEW;
      SLEW:    state_d = MULT;
      MULT:    if (bit_idx == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= 21'd0;
      target      <= LEVEL;
      cur_angle   <= LEVEL;
      product     <= 30'd0;
      bit_idx     <= 4'd11;
      next_width  <= MID_W;
      pulse_width <= MID_W;
      pwm_q       <= 1'b0;
    end else begin
      cnt   <= (cnt == LAST_CNT) ? 21'd0 : cnt + 21'd1;
      // widths are never zero, so the old width also gives the right cnt==0 sample
      pwm_q <= (cnt < pulse_width);
      if (cnt == 21'd0) pulse_width <= next_width;
      if (bus.valid) target <= bus.angle;

      case (state_q)
        SLEW: begin
          if (diff > STEP)       cur_angle <= cur_angle + STEP12;
          else if (diff < -STEP) cur_angle <= cur_angle - STEP12;
          else                   cur_angle <= target;
          product <= 30'd0;
          bit_idx <= 4'd11;
        end
        MULT: begin
          // MSB-first shift-add: twelve steps accumulate cur_angle * RANGE
          product <= {product[28:0], 1'b0} + (cur_angle[bit_idx] ? RANGE : 30'd0);
          bit_idx <= bit_idx - 4'd1;
        end
        DONE: next_width <= MIN_W + {3'd0, product[29:12]};
        default: ;
      endcase
    end
  end

endmodule
